// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, PC step and counter-width helper for the fetch front end
package fetch_pkg;
  localparam int XLEN_DEF = 32;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: pointer-based prefetch queue (extra-MSB wrap) with push/pop/flush and occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  T                        din,
  output T                        dout,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wr, rd;
  assign count = CW'(wr - rd);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !flush) mem[wr[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with credit-based prefetch queue; FETCH_MISALIGN_CHK_EN enables misaligned-redirect fault
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [XLEN-1:0] instr_pc4_o,
  output logic            fault_o
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;
  localparam int CW = cnt_w(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  logic [XLEN-1:0] fetch_pc, rsp_pc, target, last_pc, last_instr;
  logic [CW-1:0] occ, outst, discard;
  logic fault, deq, acc, keep, push;
  entry_t head;
`ifdef FETCH_MISALIGN_CHK_EN
  assign target = redirect_pc_i;
  always_ff @(posedge clk_i)
    if (rst_i) fault <= 1'b0;
    else if (redirect_i && |redirect_pc_i[1:0]) fault <= 1'b1;
`else
  assign target = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign fault = 1'b0;
`endif
  assign fault_o = fault;
  assign instr_valid_o = occ != '0;
  assign deq = instr_valid_o & instr_ready_i;
  assign imem_req_valid_o = !rst_i && !redirect_i && !fault &&
    (({1'b0, occ} + {1'b0, outst} - {{CW{1'b0}}, deq}) < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign acc = imem_req_valid_o & imem_req_ready_i;
  assign keep = imem_rsp_valid_i & (discard == '0);
  assign push = keep & !redirect_i;
  assign instr_o = instr_valid_o ? head.instr : last_instr;
  assign instr_pc_o = instr_valid_o ? head.pc : last_pc;
  assign instr_pc4_o = instr_pc_o + STEP;
  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (deq),
    .flush (redirect_i),
    .din   ('{pc: rsp_pc, instr: imem_rsp_data_i}),
    .dout  (head),
    .count (occ)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outst <= '0;
      discard <= '0;
      last_pc <= '0;
      last_instr <= '0;
    end else begin
      fetch_pc <= redirect_i ? target : acc ? fetch_pc + STEP : fetch_pc;
      rsp_pc <= redirect_i ? target : push ? rsp_pc + STEP : rsp_pc;
      outst <= outst + CW'(acc) - CW'(imem_rsp_valid_i);
      discard <= redirect_i ? outst - CW'(imem_rsp_valid_i) :
                 (imem_rsp_valid_i && discard != '0) ? discard - 1'b1 : discard;
      if (instr_valid_o) begin
        last_pc <= head.pc;
        last_instr <= head.instr;
      end
    end
  end
endmodule
